// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous Chip-8 RAM between the program
// upload port, the CPU and the blitter, one access every three cycles.
//
// Ports:
//   clk, res                 clock, synchronous active-high reset
//   uploading                program load active; only upload is eligible
//   up_req/up_a/up_d         upload write request; up_ack on issue
//   cpu_req/we/a/d           CPU access; cpu_ack on issue, cpu_rvalid on data
//   blt_req/we/a/d           blitter access; blt_ack, blt_rvalid
//   rd_q                     shared read data, qualified by the rvalids
//   ram_en/we/a/d            registered RAM command
//   ram_q                    RAM read data, one cycle after ram_en
//
// Build option: define MEM_ARB_RR_EN to alternate CPU and blitter with a
// 1-bit round-robin pointer; otherwise the blitter always beats the CPU.

module mem_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              res,
  input  logic              uploading,
  input  logic              up_req,
  input  logic [ADDR_W-1:0] up_a,
  input  logic [DATA_W-1:0] up_d,
  output logic              up_ack,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_a,
  input  logic [DATA_W-1:0] cpu_d,
  output logic              cpu_ack,
  output logic              cpu_rvalid,
  input  logic              blt_req,
  input  logic              blt_we,
  input  logic [ADDR_W-1:0] blt_a,
  input  logic [DATA_W-1:0] blt_d,
  output logic              blt_ack,
  output logic              blt_rvalid,
  output logic [DATA_W-1:0] rd_q,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_a,
  output logic [DATA_W-1:0] ram_d,
  input  logic [DATA_W-1:0] ram_q
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_RETURN = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    P_NONE = 2'd0,
    P_UP   = 2'd1,
    P_CPU  = 2'd2,
    P_BLT  = 2'd3
  } port_t;

  state_t            state_q, state_d;
  port_t             win_q, win_d;
  logic              wr_q, wr_d;
  logic              ram_en_q, ram_en_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_a_q, ram_a_d;
  logic [DATA_W-1:0] ram_wd_q, ram_wd_d;

  // Eligibility: upload owns the RAM while uploading; CPU and blitter
  // requests simply stay pending until it drops.
  logic up_ok, cpu_ok, blt_ok;
  logic pick_up, pick_cpu, pick_blt;

  assign up_ok  = uploading && up_req;
  assign cpu_ok = !uploading && cpu_req;
  assign blt_ok = !uploading && blt_req;
  assign pick_up = up_ok;

`ifdef MEM_ARB_RR_EN
  // ptr_q=0: CPU wins a tie, ptr_q=1: blitter wins a tie.
  logic ptr_q, ptr_d;
  assign pick_cpu = cpu_ok && (!blt_ok || !ptr_q);
`else
  assign pick_cpu = cpu_ok && !blt_ok;
`endif

  assign pick_blt = blt_ok && !pick_cpu;

  // State register.
  always_ff @(posedge clk) begin
    if (res) begin
      state_q  <= S_IDLE;
      win_q    <= P_NONE;
      wr_q     <= 1'b0;
      ram_en_q <= 1'b0;
      ram_we_q <= 1'b0;
      ram_a_q  <= '0;
      ram_wd_q <= '0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      wr_q     <= wr_d;
      ram_en_q <= ram_en_d;
      ram_we_q <= ram_we_d;
      ram_a_q  <= ram_a_d;
      ram_wd_q <= ram_wd_d;
    end
  end

`ifdef MEM_ARB_RR_EN
  always_ff @(posedge clk) begin
    if (res) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  // Next-state logic: the command is latched on the grant so that
  // ram_en/ram_we are high for exactly the ISSUE cycle.
  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    wr_d     = wr_q;
    ram_en_d = 1'b0;
    ram_we_d = 1'b0;
    ram_a_d  = ram_a_q;
    ram_wd_d = ram_wd_q;
`ifdef MEM_ARB_RR_EN
    ptr_d    = ptr_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        unique case (1'b1)
          pick_up: begin
            state_d  = S_ISSUE;
            win_d    = P_UP;
            wr_d     = 1'b1;
            ram_en_d = 1'b1;
            ram_we_d = 1'b1;
            ram_a_d  = up_a;
            ram_wd_d = up_d;
          end
          pick_cpu: begin
            state_d  = S_ISSUE;
            win_d    = P_CPU;
            wr_d     = cpu_we;
            ram_en_d = 1'b1;
            ram_we_d = cpu_we;
            ram_a_d  = cpu_a;
            ram_wd_d = cpu_d;
`ifdef MEM_ARB_RR_EN
            ptr_d    = 1'b1;
`endif
          end
          pick_blt: begin
            state_d  = S_ISSUE;
            win_d    = P_BLT;
            wr_d     = blt_we;
            ram_en_d = 1'b1;
            ram_we_d = blt_we;
            ram_a_d  = blt_a;
            ram_wd_d = blt_d;
`ifdef MEM_ARB_RR_EN
            ptr_d    = 1'b0;
`endif
          end
          default: ;
        endcase
      end
      S_ISSUE:  state_d = S_RETURN;
      S_RETURN: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs: acks in ISSUE, read return in RETURN, zero elsewhere.
  always_comb begin
    up_ack     = 1'b0;
    cpu_ack    = 1'b0;
    blt_ack    = 1'b0;
    cpu_rvalid = 1'b0;
    blt_rvalid = 1'b0;
    rd_q       = '0;
    unique case (state_q)
      S_ISSUE: begin
        up_ack  = (win_q == P_UP);
        cpu_ack = (win_q == P_CPU);
        blt_ack = (win_q == P_BLT);
      end
      S_RETURN: begin
        rd_q       = ram_q;
        cpu_rvalid = (win_q == P_CPU) && !wr_q;
        blt_rvalid = (win_q == P_BLT) && !wr_q;
      end
      default: ;
    endcase
  end

  assign ram_en = ram_en_q;
  assign ram_we = ram_we_q;
  assign ram_a  = ram_a_q;
  assign ram_d  = ram_wd_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 12, sets the RAM address width (4 KB Chip-8 space).
REQ-002 Parameter DATA_W, default 8, sets the RAM data width.
REQ-003 clk  in  1  single clock; all logic rising-edge.
REQ-004 res  in  1  synchronous, active-high reset.
REQ-005 uploading  in  1  program load active; only the upload port is eligible while high.
REQ-006 up_req  in  1  upload write request; held with up_a and up_d until up_ack.
REQ-007 up_a  in  ADDR_W  upload write address.
REQ-008 up_d  in  DATA_W  upload write data.
REQ-009 up_ack  out  1  one-cycle pulse when the upload write is issued to RAM.
REQ-010 cpu_req  in  1  CPU access request; held with cpu_we, cpu_a and cpu_d until cpu_ack.
REQ-011 cpu_we  in  1  CPU write (1) or read (0).
REQ-012 cpu_a  in  ADDR_W  CPU address.
REQ-013 cpu_d  in  DATA_W  CPU write data.
REQ-014 cpu_ack  out  1  one-cycle pulse when the CPU access is issued.
REQ-015 cpu_rvalid  out  1  one-cycle pulse when rd_q holds CPU read data.
REQ-016 blt_req  in  1  blitter access request; held with blt_we, blt_a and blt_d until blt_ack.
REQ-017 blt_we  in  1  blitter write (1) or read (0).
REQ-018 blt_a  in  ADDR_W  blitter address.
REQ-019 blt_d  in  DATA_W  blitter write data.
REQ-020 blt_ack  out  1  one-cycle pulse when the blitter access is issued.
REQ-021 blt_rvalid  out  1  one-cycle pulse when rd_q holds blitter read data.
REQ-022 rd_q  out  DATA_W  shared read-data return, qualified by cpu_rvalid or blt_rvalid.
REQ-023 ram_en  out  1  registered RAM enable.
REQ-024 ram_we  out  1  registered RAM write enable.
REQ-025 ram_a  out  ADDR_W  registered RAM address.
REQ-026 ram_d  out  DATA_W  registered RAM write data.
REQ-027 ram_q  in  DATA_W  synchronous RAM read data, valid one cycle after ram_en.

Function
REQ-028 The FSM SHALL have states IDLE, ISSUE and RETURN; on reset it SHALL enter IDLE.
REQ-029 IDLE SHALL sample requests in cycle N. If any port is eligible, it SHALL latch the winner's we/a/d into ram_* and go to ISSUE at N+1; otherwise it SHALL stay in IDLE.
REQ-030 ISSUE (N+1) SHALL assert ram_en and the winner's ack for exactly one cycle, then go to RETURN.
REQ-031 RETURN (N+2) SHALL drive rd_q=ram_q. For a read it SHALL pulse the winner's rvalid; a write SHALL produce no rvalid. RETURN SHALL go to IDLE unconditionally, giving a maximum of one access per 3 cycles.
REQ-032 Priority SHALL be: upload first, then CPU/blitter (REQ-041/042). up_req SHALL be ignored while uploading=0.
REQ-033 While uploading=1, cpu_req and blt_req SHALL NOT be granted; they remain pending and are not lost.
REQ-034 An upload grant SHALL force ram_we=1.
REQ-035 A request deasserted before ack SHALL be treated as withdrawn, with no RAM access.
REQ-036 ram_en, ram_we, all acks and all rvalids SHALL be 0 in every cycle not defined above.
REQ-037 uploading rising while a CPU/blitter access is in ISSUE or RETURN SHALL let that access complete normally.

Reset
REQ-038 res=1 SHALL, at the next clock edge, force IDLE and clear ram_en, ram_we, ram_a, ram_d, rd_q, all acks and all rvalids to 0. It SHALL reset the round-robin pointer to "CPU next".
REQ-039 res asserted mid-access SHALL abandon that access: no ack or rvalid follows for it.
REQ-040 After res deasserts, the first grant is possible at the earliest 2 cycles later (sample, then ISSUE).

Configuration
REQ-041 With MEM_ARB_RR_EN defined, simultaneous CPU and blitter requests SHALL alternate by a 1-bit pointer. The pointer SHALL update only on a CPU or blitter grant, and a lone requester SHALL always win.
REQ-042 Without MEM_ARB_RR_EN, the blitter SHALL always beat the CPU and no pointer register SHALL exist.

Verification
REQ-043 CPU read a=0x200, ram holds 0x12 -> ram_en at N+1, cpu_ack at N+1, cpu_rvalid=1 and rd_q=0x12 at N+2.
REQ-044 uploading=1, 3 upload writes to 0x200..0x202 -> 3 up_acks spaced 3 cycles apart with ram_we=1; a simultaneous cpu_req gets no ack until uploading=0.
REQ-045 cpu_req and blt_req held continuously for 4 grants -> with MEM_ARB_RR_EN the order is CPU, BLT, CPU, BLT; without it the order is BLT, BLT, BLT, BLT.
REQ-046 Blitter write 0xFF to 0x050 -> blt_ack, no blt_rvalid; a subsequent blitter read of 0x050 returns 0xFF.
REQ-047 res pulsed in the ISSUE cycle of a CPU read -> no cpu_rvalid; all outputs are 0 the next cycle; a re-issued request is served normally.
